// File: rtl/speck_decrypt_unit.sv
// speck_decrypt_unit: Speck32/64 decryption of a 64-bit ciphertext as two
// independent 32-bit blocks. The ciphertext and key are loaded one nibble at a
// time. Round keys are expanded on-chip into a 22-entry store. The plaintext is
// read back one nibble at a time.
//
// Ports:
//   clk_i          rising-edge clock
//   reset_1_ni     asynchronous active-low reset
//   wr_en_i        nibble write strobe (IDLE only)
//   wr_sel_i       0 = ciphertext register, 1 = key register
//   wr_addr_i      nibble index; nibble n = bits [4n+3:4n]
//   wr_data_i      nibble value
//   start_i        begin decryption (IDLE only)
//   add_to_read_i  plaintext nibble index
//   out_o          selected plaintext nibble (combinational)
//   busy_o         high during key expansion and decryption
//   done_o         one-cycle pulse when new plaintext is valid
module speck_decrypt_unit (
   input  logic       clk_i,
   input  logic       reset_1_ni,
   input  logic       wr_en_i,
   input  logic       wr_sel_i,
   input  logic [3:0] wr_addr_i,
   input  logic [3:0] wr_data_i,
   input  logic       start_i,
   input  logic [3:0] add_to_read_i,
   output logic [3:0] out_o,
   output logic       busy_o,
   output logic       done_o
);

   localparam int unsigned ROUNDS = 22;

   typedef enum logic [1:0] {StIdle, StExpand, StDecrypt, StDone} state_e;

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [63:0] ct_q, key_q;      // storage registers, persist across runs
   logic [63:0] wct_q;            // working copy of both blocks
   logic [15:0] kcur_q;           // k[i] during expansion
   logic [15:0] l0_q, l1_q, l2_q; // sliding window l[i], l[i+1], l[i+2]
   logic [15:0] rk_q [ROUNDS];
   logic [63:0] pt_q;

   logic        load_en, exp_en, dec_en, pt_en;
   logic [15:0] l_new, k_next, rk_sel;
   logic [31:0] dec_hi, dec_lo;

   // y' = ROR(y ^ x, 2); x' = ROL((x ^ k) - y', 7)
   function automatic logic [31:0] dec_round(input logic [31:0] blk, input logic [15:0] k);
      logic [15:0] t, yn, s, xn;
      t  = blk[15:0] ^ blk[31:16];
      yn = {t[1:0], t[15:2]};
      s  = (blk[31:16] ^ k) - yn;
      xn = {s[8:0], s[15:9]};
      return {xn, yn};
   endfunction

   assign l_new  = (kcur_q + {l0_q[6:0], l0_q[15:7]}) ^ {11'b0, cnt_q};
   assign k_next = {kcur_q[13:0], kcur_q[15:14]} ^ l_new;
   assign rk_sel = rk_q[cnt_q];
   assign dec_hi = dec_round(wct_q[63:32], rk_sel);
   assign dec_lo = dec_round(wct_q[31:0], rk_sel);
   assign out_o  = pt_q[{add_to_read_i, 2'b00} +: 4];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load_en = 1'b0;
      exp_en  = 1'b0;
      dec_en  = 1'b0;
      pt_en   = 1'b0;
      busy_o  = 1'b0;
      done_o  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               load_en = 1'b1;
               cnt_d   = 5'd0;
               state_d = StExpand;
            end
         end
         StExpand: begin
            busy_o = 1'b1;
            exp_en = 1'b1;
            if (cnt_q == 5'(ROUNDS - 2)) begin
               cnt_d   = 5'(ROUNDS - 1);
               state_d = StDecrypt;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         StDecrypt: begin
            busy_o = 1'b1;
            dec_en = 1'b1;
            if (cnt_q == 5'd0) begin
               pt_en   = 1'b1;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q - 5'd1;
            end
         end
         StDone: begin
            done_o  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_1_ni) begin
      if (!reset_1_ni) begin
         state_q <= StIdle;
         cnt_q   <= 5'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // A write in the start cycle lands here, while the run copies the old contents.
   always_ff @(posedge clk_i or negedge reset_1_ni) begin
      if (!reset_1_ni) begin
         ct_q  <= 64'd0;
         key_q <= 64'd0;
      end else if (state_q == StIdle && wr_en_i) begin
         if (wr_sel_i) key_q[{wr_addr_i, 2'b00} +: 4] <= wr_data_i;
         else          ct_q[{wr_addr_i, 2'b00} +: 4]  <= wr_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge reset_1_ni) begin
      if (!reset_1_ni) begin
         wct_q  <= 64'd0;
         kcur_q <= 16'd0;
         l0_q   <= 16'd0;
         l1_q   <= 16'd0;
         l2_q   <= 16'd0;
         pt_q   <= 64'd0;
         for (int i = 0; i < ROUNDS; i++) rk_q[i] <= 16'd0;
      end else begin
         if (load_en) begin
            wct_q    <= ct_q;
            kcur_q   <= key_q[15:0];
            l0_q     <= key_q[31:16];
            l1_q     <= key_q[47:32];
            l2_q     <= key_q[63:48];
            rk_q[0]  <= key_q[15:0];
         end
         if (exp_en) begin
            l0_q                <= l1_q;
            l1_q                <= l2_q;
            l2_q                <= l_new;
            kcur_q              <= k_next;
            rk_q[cnt_q + 5'd1]  <= k_next;
         end
         if (dec_en) wct_q <= {dec_hi, dec_lo};
         if (pt_en)  pt_q  <= {dec_hi, dec_lo};
      end
   end

endmodule

// File: tb/tb_speck_decrypt_unit.sv
`timescale 1ns/1ps
module tb_speck_decrypt_unit;

   logic       clk_i = 1'b0;
   logic       reset_1_ni;
   logic       wr_en_i, wr_sel_i, start_i;
   logic [3:0] wr_addr_i, wr_data_i, add_to_read_i;
   logic [3:0] out_o;
   logic       busy_o, done_o;

   int checks = 0;
   int failures = 0;
   logic [63:0] prev_pt;

   localparam logic [63:0] KatKey = 64'h1918_1110_0908_0100;
   localparam logic [63:0] KatCt  = 64'ha86842f2_a86842f2;
   localparam logic [63:0] KatPt  = 64'h6574694c_6574694c;

   speck_decrypt_unit dut (
      .clk_i         (clk_i),
      .reset_1_ni    (reset_1_ni),
      .wr_en_i       (wr_en_i),
      .wr_sel_i      (wr_sel_i),
      .wr_addr_i     (wr_addr_i),
      .wr_data_i     (wr_data_i),
      .start_i       (start_i),
      .add_to_read_i (add_to_read_i),
      .out_o         (out_o),
      .busy_o        (busy_o),
      .done_o        (done_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [15:0] ror16(input logic [15:0] v, input int r);
      return (v >> r) | (v << (16 - r));
   endfunction

   function automatic logic [15:0] rol16(input logic [15:0] v, input int r);
      return (v << r) | (v >> (16 - r));
   endfunction

   function automatic logic [31:0] speck_blk(input logic [31:0] blk, input logic [63:0] key,
                                             input bit enc);
      logic [15:0] k [22];
      logic [15:0] l [24];
      logic [15:0] x, y;
      k[0] = key[15:0];
      l[0] = key[31:16];
      l[1] = key[47:32];
      l[2] = key[63:48];
      for (int i = 0; i < 21; i++) begin
         l[i+3] = (k[i] + ror16(l[i], 7)) ^ 16'(i);
         k[i+1] = rol16(k[i], 2) ^ l[i+3];
      end
      x = blk[31:16];
      y = blk[15:0];
      if (enc) begin
         for (int r = 0; r < 22; r++) begin
            x = (ror16(x, 7) + y) ^ k[r];
            y = rol16(y, 2) ^ x;
         end
      end else begin
         for (int r = 21; r >= 0; r--) begin
            y = ror16(y ^ x, 2);
            x = rol16((x ^ k[r]) - y, 7);
         end
      end
      return {x, y};
   endfunction

   function automatic logic [63:0] model64(input logic [63:0] d, input logic [63:0] key,
                                           input bit enc);
      return {speck_blk(d[63:32], key, enc), speck_blk(d[31:0], key, enc)};
   endfunction

   // ---------------- drivers ----------------
   task automatic write_nib(input logic sel, input int addr, input logic [3:0] data);
      @(negedge clk_i);
      wr_en_i   = 1'b1;
      wr_sel_i  = sel;
      wr_addr_i = 4'(addr);
      wr_data_i = data;
      @(posedge clk_i);
      #1;
      wr_en_i = 1'b0;
   endtask

   task automatic load(input logic [63:0] ct, input logic [63:0] key);
      for (int n = 0; n < 16; n++) write_nib(1'b0, n, ct[4*n +: 4]);
      for (int n = 0; n < 16; n++) write_nib(1'b1, n, key[4*n +: 4]);
   endtask

   task automatic read_pt(output logic [63:0] v);
      for (int n = 0; n < 16; n++) begin
         add_to_read_i = 4'(n);
         #0.2;
         v[4*n +: 4] = out_o;
      end
   endtask

   // Starts a run and watches busy/done cycle by cycle. inject_at >= 1 pulses
   // stray writes and a stray start while busy; ws writes ct nibble 0 in the start cycle.
   task automatic run(input string tag, input logic [63:0] exp_pt, input int inject_at,
                      input bit ws, input logic [3:0] ws_data);
      logic [63:0] rd;
      bit ok;
      ok = 1'b1;
      @(negedge clk_i);
      start_i = 1'b1;
      if (ws) begin
         wr_en_i   = 1'b1;
         wr_sel_i  = 1'b0;
         wr_addr_i = 4'd0;
         wr_data_i = ws_data;
      end
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      wr_en_i = 1'b0;
      for (int k = 1; k <= 45; k++) begin
         @(negedge clk_i);
         if (k == inject_at + 2) begin
            start_i = 1'b0;
            wr_en_i = 1'b0;
         end
         if (k <= 43) begin
            if (busy_o !== 1'b1 || done_o !== 1'b0) ok = 1'b0;
         end else if (k == 44) begin
            if (busy_o !== 1'b0 || done_o !== 1'b1) ok = 1'b0;
         end else begin
            if (busy_o !== 1'b0 || done_o !== 1'b0) ok = 1'b0;
         end
         if (k == 43) begin
            read_pt(rd);
            check_eq({tag, "_hold"}, rd, prev_pt);
         end
         if (k == 44) begin
            read_pt(rd);
            check_eq({tag, "_pt"}, rd, exp_pt);
            prev_pt = exp_pt;
         end
         if (k == inject_at) begin
            start_i   = 1'b1;
            wr_en_i   = 1'b1;
            wr_sel_i  = 1'b0;
            wr_addr_i = 4'd5;
            wr_data_i = 4'hb;
         end
         if (k == inject_at + 1) begin
            wr_sel_i  = 1'b1;
            wr_addr_i = 4'd2;
            wr_data_i = 4'h7;
         end
      end
      check_eq({tag, "_timing"}, 64'(ok), 64'd1);
   endtask

   // ---------------- sequence ----------------
   initial begin
      logic [63:0] rd, ct_new, key, pt, ct;
      bit ok;
      reset_1_ni    = 1'b0;
      wr_en_i       = 1'b0;
      wr_sel_i      = 1'b0;
      wr_addr_i     = 4'd0;
      wr_data_i     = 4'd0;
      start_i       = 1'b0;
      add_to_read_i = 4'd0;
      prev_pt       = 64'd0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      read_pt(rd);
      check_eq("reset_pt", rd, 64'd0);
      check_eq("reset_busy", 64'(busy_o), 64'd0);
      check_eq("reset_done", 64'(done_o), 64'd0);
      reset_1_ni = 1'b1;

      // Known answer
      load(KatCt, KatKey);
      run("kat", KatPt, -10, 1'b0, 4'h0);

      // Mixed blocks: lower block zero
      for (int n = 0; n < 8; n++) write_nib(1'b0, n, 4'h0);
      run("mixed", {32'h6574694c, speck_blk(32'h0, KatKey, 1'b0)}, -10, 1'b0, 4'h0);

      // Stray writes and start while busy; storage must be untouched
      for (int n = 0; n < 8; n++) write_nib(1'b0, n, KatCt[4*n +: 4]);
      run("proto", KatPt, 10, 1'b0, 4'h0);
      run("proto_again", KatPt, -10, 1'b0, 4'h0);

      // Write and start in the same cycle
      ct_new = KatCt;
      ct_new[3:0] = 4'h0;
      run("ws_old", KatPt, -10, 1'b1, 4'h0);
      run("ws_new", model64(ct_new, KatKey, 1'b0), -10, 1'b0, 4'h0);

      // Reset in the middle of a run
      @(negedge clk_i);
      start_i = 1'b1;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      for (int k = 1; k <= 30; k++) @(negedge clk_i);
      reset_1_ni = 1'b0;
      #1;
      read_pt(rd);
      check_eq("rst_mid_pt", rd, 64'd0);
      check_eq("rst_mid_busy", 64'(busy_o), 64'd0);
      ok = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk_i);
         if (done_o !== 1'b0 || busy_o !== 1'b0) ok = 1'b0;
      end
      reset_1_ni = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk_i);
         if (done_o !== 1'b0 || busy_o !== 1'b0) ok = 1'b0;
      end
      check_eq("rst_mid_no_done", 64'(ok), 64'd1);
      prev_pt = 64'd0;
      load(KatCt, KatKey);
      run("kat_after_rst", KatPt, -10, 1'b0, 4'h0);

      // Random key/plaintext pairs
      for (int t = 0; t < 200; t++) begin
         key = {$urandom, $urandom};
         pt  = {$urandom, $urandom};
         ct  = model64(pt, key, 1'b1);
         load(ct, key);
         run("rnd", pt, -10, 1'b0, 4'h0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/speck_decrypt_unit.md
# speck_decrypt_unit

Receive-side counterpart of the encrypting processor top: takes a 64-bit ciphertext and 64-bit key loaded nibble-by-nibble, decrypts it with Speck32/64 as two independent 32-bit blocks, and exposes the plaintext through a 4-bit nibble read port addressed like the encryptor's `add_to_read`/`out` pair. It contains its own key expansion, a round-key store and a multi-cycle decrypt FSM.

## Interface
- `ROUNDS`, 22, Speck32/64 round count; fixed, not to be overridden.
- `clk` in 1: single clock, rising edge.
- `reset_1` in 1: asynchronous, active-low reset.
- `wr_en` in 1: nibble write strobe; honoured only in IDLE.
- `wr_sel` in 1: 0 = ciphertext register, 1 = key register.
- `wr_addr` in 4: nibble index; nibble n = bits [4n+3:4n].
- `wr_data` in 4: nibble value.
- `start` in 1: begin decryption; honoured only in IDLE.
- `add_to_read` in 4: plaintext nibble index.
- `out` out 4: plaintext nibble `pt[4*add_to_read+3 : 4*add_to_read]`, combinational from the plaintext register.
- `busy` out 1: high while in EXPAND or DECRYPT.
- `done` out 1: one-cycle pulse when plaintext is valid.

## Operation
- Key words: `k0=key[15:0]`, `l0=key[31:16]`, `l1=key[47:32]`, `l2=key[63:48]`.
- Block j (j=0,1) is `ct[32j+31:32j]`. Within a block, x = upper 16 bits and y = lower 16 bits.
- Key expansion for i=0..20:
  - `l[i+3] = (k[i] + ROR(l[i],7)) ^ i`
  - `k[i+1] = ROL(k[i],2) ^ l[i+3]`
  - All arithmetic is 16-bit mod 2^16. `k[0..21]` are stored in a 22×16 register array.
- Decrypt round with key k: `y' = ROR(y ^ x, 2)`, `x' = ROL((x ^ k) - y', 7)`, subtraction mod 2^16.
  - Applied with k[21] down to k[0].
  - Both blocks use parallel datapaths and the same round key each cycle.
- FSM states:
  - IDLE: on `start`, load the working copies of ct and key, clear the round counter, go to EXPAND.
  - EXPAND: 21 cycles, counter 0→20, then go to DECRYPT.
  - DECRYPT: 22 cycles, counter 21→0. The final cycle writes the plaintext register; then go to DONE.
  - DONE: one cycle with `done`=1, then IDLE.
- `wr_en` and `start` in the same IDLE cycle: the write lands in the storage register, but this run uses the pre-write contents.
- `wr_en` or `start` outside IDLE: ignored, with no side effects.
- The ciphertext and key storage registers persist across runs. `start` with no new writes re-decrypts the same data.

## Timing
- Reset (asynchronous assert, any state): FSM→IDLE; ct, key, round-key array, working regs and plaintext = 0; `out`=0, `busy`=0, `done`=0.
- Release of `reset_1` is synchronous to `clk`.
- Reset mid-run aborts the run. The plaintext register stays 0, and `done` does not fire.
- `start` sampled high at edge T:
  - `busy`=1 for cycles T+1..T+43.
  - `done`=1 only in cycle T+44; `busy`=0 in that cycle.
  - New plaintext is visible on `out` from cycle T+44.
  - The next `start` is accepted at edge T+45 or later.
- The plaintext register holds its old value throughout a run and changes only at the final DECRYPT edge.
- A nibble write at edge T is visible for a `start` at edge T+1.
- The round-counter XOR constant is the 16-bit zero-extended i; i is never above 20.

## Test plan
- Known-answer:
  - Stimulus: key=64'h1918_1110_0908_0100, ct=64'ha86842f2_a86842f2, `start`.
  - Response: after `done`, reading nibbles 0..15 yields pt=64'h6574694c_6574694c; `done` comes exactly 44 cycles after the start edge.
- Mixed blocks:
  - Stimulus: ct upper block = 32'ha86842f2, lower block = 32'h00000000, same key.
  - Response: the upper 32 bits of pt = 32'h6574694c, and the lower 32 bits match the reference model's decryption of 0.
- Protocol:
  - Stimulus: writes and a second `start` pulsed at T+10 while busy.
  - Response: ignored; the result equals the known-answer result, and ct and key storage are unchanged.
- Same-cycle write+start:
  - Stimulus: nibble 0 of ct changed in the start cycle.
  - Response: the result matches the old ct; a second `start` then decrypts the new ct.
- Reset mid-run:
  - Stimulus: assert `reset_1`=0 at T+30.
  - Response: `out`=0 for all addresses, `busy`=0, and no `done`. A fresh load plus `start` then gives the known-answer result.
- Random:
  - Stimulus: 200 random key/plaintext pairs encrypted by the software model.
  - Response: the decrypted output matches the plaintext; `busy`/`done` timing holds for every run.
